// File: rtl/rv32i_mem_pkg.sv
// Shared definitions for the RV32I load/store sequencer: funct3 width codes,
// memory line geometry, sequencer state encoding and the width-to-size decode.
package rv32i_mem_pkg;

  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned LINE_W     = 8 * LINE_BYTES;
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES);

  // funct3 load/store width codes
  localparam logic [2:0] W_B  = 3'b000;
  localparam logic [2:0] W_H  = 3'b001;
  localparam logic [2:0] W_W  = 3'b010;
  localparam logic [2:0] W_BU = 3'b100;
  localparam logic [2:0] W_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Access size in bytes; 0 marks an illegal width code.
  function automatic logic [2:0] width_size(input logic [2:0] width);
    case (width)
      W_B, W_BU: width_size = 3'd1;
      W_H, W_HU: width_size = 3'd2;
      W_W:       width_size = 3'd4;
      default:   width_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Places an access onto memory byte lanes for one beat.
//   off        : byte offset of the access within its line
//   size       : access size in bytes (1, 2, 4; anything else gives no lanes)
//   wdata      : store data, low bytes significant
//   beat       : 0 = first line, 1 = bytes spilled into the following line
//   be         : byte enables for the selected beat
//   lane_wdata : write data shifted onto the selected beat's lanes
module mem_lane_align
  import rv32i_mem_pkg::*;
(
  input  logic [OFF_W-1:0]      off,
  input  logic [2:0]            size,
  input  logic [31:0]           wdata,
  input  logic                  beat,
  output logic [LINE_BYTES-1:0] be,
  output logic [LINE_W-1:0]     lane_wdata
);

  localparam int unsigned BE2_W  = 2 * LINE_BYTES;
  localparam int unsigned DAT2_W = 2 * LINE_W;

  logic [3:0]        size_be;
  logic [BE2_W-1:0]  be_full;
  logic [DAT2_W-1:0] wd_full;

  // Shift across a two-line window; the upper half is what spills into beat 1.
  always_comb begin
    case (size)
      3'd1:    size_be = 4'h1;
      3'd2:    size_be = 4'h3;
      3'd4:    size_be = 4'hF;
      default: size_be = 4'h0;
    endcase
    be_full = BE2_W'(size_be) << off;
    wd_full = DAT2_W'(wdata) << {off, 3'b000};
    if (beat) begin
      be         = be_full[BE2_W-1:LINE_BYTES];
      lane_wdata = wd_full[DAT2_W-1:LINE_W];
    end else begin
      be         = be_full[LINE_BYTES-1:0];
      lane_wdata = wd_full[LINE_W-1:0];
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Load/store sequencer between the RV32I execute stage and a line-wide memory.
// Accepts one B/H/W access per handshake, issues one or two line beats
// (two when the access crosses a line), reassembles and extends load data,
// and returns a single response pulse.
//   clk, rst                 : clock, async active-high reset
//   cpu_valid/cpu_ready      : request handshake
//   cpu_we/width/addr/wdata  : access descriptor
//   rsp_valid/rdata/err      : one-cycle completion with load data / error
//   mem_req/we/addr/be/wdata : registered memory beat, held until mem_ack
//   mem_ack/mem_rdata        : beat completion with line read data
module mem_access_sequencer
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_valid,
  output logic                  cpu_ready,
  input  logic                  cpu_we,
  input  logic [2:0]            cpu_width,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [LINE_BYTES-1:0] mem_be,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [LINE_W-1:0]     mem_rdata
);

  localparam int unsigned SUM_W = OFF_W + 2;

  state_e state_q, state_d;

  logic              lat_we_q, lat_we_d;
  logic [2:0]        lat_width_q, lat_width_d;
  logic [OFF_W-1:0]  lat_off_q, lat_off_d;
  logic [2:0]        lat_size_q, lat_size_d;
  logic [31:0]       lat_wdata_q, lat_wdata_d;
  logic              split_q, split_d;
  logic [31:0]       win_q, win_d;

  logic                  cpu_ready_d, rsp_valid_d, rsp_err_d;
  logic [31:0]           rsp_rdata_d;
  logic                  mem_req_d, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_d;
  logic [LINE_BYTES-1:0] mem_be_d;
  logic [LINE_W-1:0]     mem_wdata_d;

  logic [2:0]            acc_size;
  logic [OFF_W-1:0]      al_off;
  logic [2:0]            al_size;
  logic [31:0]           al_wdata;
  logic                  al_beat;
  logic [LINE_BYTES-1:0] al_be;
  logic [LINE_W-1:0]     al_lane_wdata;
  logic [31:0]           win_b0, win_b1;

  function automatic logic [31:0] size_mask(input logic [2:0] size);
    case (size)
      3'd1:    size_mask = 32'h0000_00FF;
      3'd2:    size_mask = 32'h0000_FFFF;
      3'd4:    size_mask = 32'hFFFF_FFFF;
      default: size_mask = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] width, input logic [31:0] w);
    case (width)
      W_B:     load_extend = {{24{w[7]}}, w[7:0]};
      W_H:     load_extend = {{16{w[15]}}, w[15:0]};
      W_BU:    load_extend = {24'h0, w[7:0]};
      W_HU:    load_extend = {16'h0, w[15:0]};
      W_W:     load_extend = w;
      default: load_extend = 32'h0;
    endcase
  endfunction

  assign acc_size = width_size(cpu_width);

  // In IDLE the aligner prepares beat 0 from the live request; afterwards it
  // works on the latched access and prepares beat 1.
  assign al_off   = (state_q == IDLE) ? cpu_addr[OFF_W-1:0] : lat_off_q;
  assign al_size  = (state_q == IDLE) ? acc_size : lat_size_q;
  assign al_wdata = (state_q == IDLE) ? cpu_wdata : lat_wdata_q;
  assign al_beat  = (state_q == BEAT0);

  mem_lane_align u_align (
    .off        (al_off),
    .size       (al_size),
    .wdata      (al_wdata),
    .beat       (al_beat),
    .be         (al_be),
    .lane_wdata (al_lane_wdata)
  );

  // Window bytes pulled from each beat; bytes belonging to the other beat shift in as zero.
  assign win_b0 = 32'({LINE_W'(0), mem_rdata} >> {lat_off_q, 3'b000}) & size_mask(lat_size_q);
  assign win_b1 = 32'({mem_rdata, LINE_W'(0)} >> {lat_off_q, 3'b000}) & size_mask(lat_size_q);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    lat_we_d    = lat_we_q;
    lat_width_d = lat_width_q;
    lat_off_d   = lat_off_q;
    lat_size_d  = lat_size_q;
    lat_wdata_d = lat_wdata_q;
    split_d     = split_q;
    win_d       = win_q;
    cpu_ready_d = cpu_ready;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_be_d    = mem_be;
    mem_wdata_d = mem_wdata;

    case (state_q)
      IDLE: begin
        if (cpu_valid && cpu_ready) begin
          lat_we_d    = cpu_we;
          lat_width_d = cpu_width;
          lat_off_d   = cpu_addr[OFF_W-1:0];
          lat_size_d  = acc_size;
          lat_wdata_d = cpu_wdata;
          split_d     = (SUM_W'(cpu_addr[OFF_W-1:0]) + SUM_W'(acc_size)) > SUM_W'(LINE_BYTES);
          win_d       = 32'h0;
          cpu_ready_d = 1'b0;
          if (acc_size != 3'd0) begin
            state_d     = BEAT0;
            mem_req_d   = 1'b1;
            mem_we_d    = cpu_we;
            mem_addr_d  = {cpu_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            mem_be_d    = al_be;
            mem_wdata_d = al_lane_wdata;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      BEAT0: begin
        if (mem_ack) begin
          win_d = win_b0;
          if (split_q) begin
            state_d     = BEAT1;
            mem_addr_d  = mem_addr + ADDR_W'(LINE_BYTES);
            mem_be_d    = al_be;
            mem_wdata_d = al_lane_wdata;
          end else begin
            state_d     = RESP;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_be_d    = '0;
            mem_wdata_d = '0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = lat_we_q ? 32'h0 : load_extend(lat_width_q, win_d);
          end
        end
      end
      BEAT1: begin
        if (mem_ack) begin
          win_d       = win_q | win_b1;
          state_d     = RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = lat_we_q ? 32'h0 : load_extend(lat_width_q, win_d);
        end
      end
      RESP: begin
        state_d     = IDLE;
        cpu_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        cpu_ready_d = 1'b1;
      end
    endcase
  end

  // State, latched access and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_we_q    <= 1'b0;
      lat_width_q <= 3'h0;
      lat_off_q   <= '0;
      lat_size_q  <= 3'h0;
      lat_wdata_q <= 32'h0;
      split_q     <= 1'b0;
      win_q       <= 32'h0;
      cpu_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'h0;
      rsp_err     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
    end else begin
      state_q     <= state_d;
      lat_we_q    <= lat_we_d;
      lat_width_q <= lat_width_d;
      lat_off_q   <= lat_off_d;
      lat_size_q  <= lat_size_d;
      lat_wdata_q <= lat_wdata_d;
      split_q     <= split_d;
      win_q       <= win_d;
      cpu_ready   <= cpu_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_be      <= mem_be_d;
      mem_wdata   <= mem_wdata_d;
    end
  end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Load/store sequencer between the RV32I execute stage and the 128-bit line-wide data memory port. It accepts one byte, halfword or word access per handshake and generates the 16-bit byte-enable mask and lane-shifted write data. Accesses that cross a 16-byte line are split into two memory beats. On loads it reassembles the bytes and sign- or zero-extends them before returning a single response.

## Interface
- LINE_BYTES, 16, bytes per memory line (fixed power of two; mem_be width)
- ADDR_W, 32, address width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_valid  in  1  access request
- cpu_ready  out  1  sequencer idle; request accepted when cpu_valid && cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_width  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
- cpu_addr  in  ADDR_W  byte address, any alignment
- cpu_wdata  in  32  store data, low bytes significant
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  illegal width, valid with rsp_valid
- mem_req  out  1  memory beat request
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  line-aligned address (low 4 bits zero)
- mem_be  out  LINE_BYTES  byte enables for the beat
- mem_wdata  out  8*LINE_BYTES  lane-aligned write data
- mem_ack  in  1  beat complete; mem_rdata valid the same cycle
- mem_rdata  in  8*LINE_BYTES  line read data

## Operation
- States: IDLE, BEAT0, BEAT1, RESP. Reset state is IDLE.
- Accept rules:
  - On accept, latch we, width, addr and wdata.
  - size = 1, 2 or 4 bytes.
  - off = addr[3:0].
  - split = (off + size > 16).
- IDLE: cpu_ready = 1. Accept with a legal width goes to BEAT0. Accept with an illegal width goes to RESP with err = 1 and makes no memory access.
- BEAT0:
  - mem_addr = {addr[31:4], 4'h0}.
  - mem_be = ((1<<size)-1) << off, truncated to 16 bits.
  - mem_wdata = wdata << 8*off, truncated.
  - On mem_ack: capture the enabled read bytes, then go to BEAT1 if split, else RESP.
- BEAT1:
  - mem_addr = previous line + 16.
  - mem_be and mem_wdata carry the spilled bytes, placed at lanes 0..(off+size-17).
  - On mem_ack: capture bytes, then go to RESP.
- RESP: rsp_valid = 1 for one cycle, then return to IDLE.
- Load result:
  - Byte k of the window = captured line byte off+k from beat0, or byte off+k-16 from beat1.
  - B and H sign-extend from bit 7 or bit 15; BU and HU zero-extend; W passes through.
- mem_req, mem_we, mem_addr, mem_be and mem_wdata are registered. They are held stable from the assertion of mem_req until the cycle mem_ack is sampled high.
- mem_ack outside BEAT0/BEAT1 is ignored. cpu_valid outside IDLE is ignored.

## Timing
- Reset values:
  - Outputs: cpu_ready = 1; all other outputs 0.
  - Internal latches: cleared.
- Reset mid-transaction aborts the access: mem_req drops asynchronously and no rsp_valid is produced.
- Accept in cycle T puts mem_req high in T+1.
- An ack in cycle A produces the next beat's mem_req in A+1, or rsp_valid in A+1.
- Minimum latencies, with the same-cycle ack:
  - Single beat: rsp at T+2.
  - Split: rsp at T+3.
  - Illegal width: rsp at T+1.
- cpu_ready is low from T+1 through the RESP cycle. The next accept is possible at the earliest one cycle after rsp_valid.
- Wait time for mem_ack is unbounded; there is no timeout.

## Structure
- Package rv32i_mem_pkg holds:
  - funct3 width constants (W_B, W_H, W_W, W_BU, W_HU)
  - LINE_BYTES
  - the state enum (IDLE, BEAT0, BEAT1, RESP)
  - a width-to-size function
- One combinational sub-module, mem_lane_align. Inputs: off, size, wdata, beat. Outputs: be, shifted wdata.
- FSM, capture registers and the load extender live in the top module.

## Test plan
- SW at 0x104, wdata 0xDEADBEEF, ack one cycle after mem_req:
  - mem_addr 0x100, mem_be 0x00F0, mem_wdata[63:32] = 0xDEADBEEF.
  - Single beat, rsp_valid with rsp_err = 0.
- LB and LBU at 0x20F, mem_rdata byte 15 = 0x80:
  - One beat, mem_be 0x8000.
  - rsp_rdata 0xFFFFFF80 for LB, 0x00000080 for LBU.
- LW at 0x10E, beat0 bytes 14..15 = 0x11, 0x22 and beat1 bytes 0..1 = 0x33, 0x44:
  - Beat0: addr 0x100, be 0xC000.
  - Beat1: addr 0x110, be 0x0003.
  - rsp_rdata 0x44332211.
- Store with cpu_width 011:
  - mem_req never asserts.
  - rsp_valid at T+1 with rsp_err = 1, rsp_rdata 0.
- SH at 0x1FF, rst asserted during BEAT1 before mem_ack:
  - mem_req drops immediately, cpu_ready = 1, no rsp_valid.
  - A following LW at 0x0 completes normally.
- mem_ack held low for 20 cycles with cpu_valid toggling:
  - mem_* outputs stay constant and cpu_ready stays 0.
  - Exactly one rsp_valid after the ack.
